// File: rtl/store_merge_unit.sv
// store_merge_unit: store path of the multicycle MIPS datapath. It narrows a
// register value to a word, halfword or byte and writes it to word-addressed
// data memory. Halfword and byte stores read the containing word, merge the
// new lane and write the word back.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   start             request pulse, sampled only while idle
//   size              00 word, 01 halfword, 10 byte, 11 treated as word
//   addr, reg_data    byte address and source data of the store
//   mem_rdata         memory read data, one cycle after a read address
//   mem_addr          word-aligned memory address
//   mem_wdata, mem_wr write data and a one-cycle write strobe
//   busy, done        busy outside IDLE; one-cycle completion pulse
//   misaligned        one-cycle alignment-fault pulse
//
// Optional feature: define STORE_ALIGN_CHECK_EN to reject misaligned word and
// halfword stores (no write; misaligned and done pulse together). Without it,
// misaligned is tied low and the low address bits are ignored.

module store_merge_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_MERGE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged;
  logic        sub_word_in;

`ifdef STORE_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic fault_in;

  // Fault decode on the live request, so the decision is made on the start edge.
  always_comb begin
    fault_in = 1'b0;
    if (size == 2'b01) begin
      fault_in = addr[0];
    end else if (size != 2'b10) begin
      fault_in = (addr[1:0] != 2'b00);
    end
  end
`endif

  // Only halfword and byte stores need the read-modify-write path.
  assign sub_word_in = (size == 2'b01) || (size == 2'b10);

  // Lane merge: start from the fetched word and overwrite the addressed lane.
  always_comb begin
    merged = data_q;
    case (size_q)
      2'b01: begin
        merged = rdata_q;
        if (addr_q[1]) begin
          merged[31:16] = data_q[15:0];
        end else begin
          merged[15:0] = data_q[15:0];
        end
      end
      2'b10: begin
        merged = rdata_q;
        merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
      end
      default: merged = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
`ifdef STORE_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = addr;
          size_d = size;
          data_d = reg_data;
          if (sub_word_in) begin
            state_d = S_READ;
          end else begin
            // Word stores skip the read; the write data is ready at once.
            state_d = S_WRITE;
            wdata_d = reg_data;
          end
`ifdef STORE_ALIGN_CHECK_EN
          mis_d = fault_in;
          if (fault_in) begin
            state_d = S_DONE;
            wdata_d = wdata_q;
          end
`endif
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        rdata_d = mem_rdata;
        state_d = S_MERGE;
      end
      S_MERGE: begin
        wdata_d = merged;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
`ifdef STORE_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
`ifdef STORE_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Strobes decode straight from the state register, so reset clears them
  // without waiting for a clock edge.
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wr    = (state_q == S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
`ifdef STORE_ALIGN_CHECK_EN
  assign misaligned = (state_q == S_DONE) && mis_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] reg_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        misaligned;

  store_merge_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .size       (size),
    .addr       (addr),
    .reg_data   (reg_data),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .busy       (busy),
    .done       (done),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  // Memory environment: 64 words, one-cycle read latency, plus a preload port.
  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  // Reference copy of memory, maintained by the model.
  logic [31:0] ref_mem [0:63];

  int n_chk  = 0;
  int n_pass = 0;

  // Observations of one store, counted in cycles after the start edge.
  int          o_wr_cnt, o_wr_cyc, o_done_cnt, o_done_cyc, o_mis_cnt, o_mis_cyc, o_idle_cyc;
  logic [31:0] o_wdata, o_waddr, o_raddr;

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the first idle negedge.
  // poke_last: start is held high with junk inputs up to that cycle.
  task automatic run_store(input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input int poke_last);
    o_wr_cnt = 0; o_wr_cyc = -1; o_done_cnt = 0; o_done_cyc = -1;
    o_mis_cnt = 0; o_mis_cyc = -1; o_idle_cyc = -1;
    o_wdata = '0; o_waddr = '0; o_raddr = '0;
    start = 1'b1; size = sz; addr = a; reg_data = d;
    @(posedge clk);
    #1;
    start = 1'b0; size = 2'($urandom); addr = $urandom; reg_data = $urandom;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) o_raddr = mem_addr;
      if (mem_wr) begin o_wr_cnt++; o_wr_cyc = c; o_wdata = mem_wdata; o_waddr = mem_addr; end
      if (done) begin o_done_cnt++; o_done_cyc = c; end
      if (misaligned) begin o_mis_cnt++; o_mis_cyc = c; end
      if (!busy) begin o_idle_cyc = c; break; end
      if (c + 1 <= poke_last) begin
        start = 1'b1; size = 2'($urandom); addr = $urandom; reg_data = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  // Behavioural store model: mask-and-shift on the old word plus fixed latencies.
  function automatic void model(input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] old,
                                output logic [31:0] w, output int wr_cyc,
                                output int done_cyc, output bit fault);
    logic [31:0] mask, lane;
    int sh;
    fault = 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
    if (sz == 2'b01) fault = a[0];
    else if (sz != 2'b10) fault = (a[1:0] != 2'b00);
`endif
    if (sz == 2'b10) begin
      sh = 8 * int'(a[1:0]);
      mask = 32'hFF << sh; lane = (d & 32'hFF) << sh;
    end else if (sz == 2'b01) begin
      sh = a[1] ? 16 : 0;
      mask = 32'hFFFF << sh; lane = (d & 32'hFFFF) << sh;
    end else begin
      mask = 32'hFFFF_FFFF; lane = d;
    end
    w = (old & ~mask) | lane;
    if (fault) begin wr_cyc = -1; done_cyc = 1; end
    else if (sz == 2'b01 || sz == 2'b10) begin wr_cyc = 4; done_cyc = 5; end
    else begin wr_cyc = 1; done_cyc = 2; end
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if ({mem_wr, busy, done, misaligned} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {mem_wr, busy, done, misaligned}); else n_pass++;
    n_chk++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr); else n_pass++;
    n_chk++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 00000000", mem_wdata); else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
  endtask

  task automatic test_word;
    run_store(2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    n_chk++; if (o_wr_cnt !== 1 || o_wr_cyc !== 1) $display("FAIL word_write_cycle: got cnt %0d cyc %0d want 1 1", o_wr_cnt, o_wr_cyc); else n_pass++;
    n_chk++; if (o_waddr !== 32'h10) $display("FAIL word_mem_addr: got %h want 00000010", o_waddr); else n_pass++;
    n_chk++; if (o_wdata !== 32'hDEAD_BEEF) $display("FAIL word_wdata: got %h want deadbeef", o_wdata); else n_pass++;
    n_chk++; if (o_done_cnt !== 1 || o_done_cyc !== 2 || o_idle_cyc !== 3) $display("FAIL word_timing: got done %0d idle %0d want 2 3", o_done_cyc, o_idle_cyc); else n_pass++;
    n_chk++; if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL word_memory: got %h want deadbeef", mem[4]); else n_pass++;
    ref_mem[4] = 32'hDEAD_BEEF;
  endtask

  task automatic test_subword;
    preload(6'd4, 32'h1122_3344);
    run_store(2'b10, 32'h0000_0013, 32'hFFFF_FFA5, 0);
    n_chk++; if (o_raddr !== 32'h10) $display("FAIL sb_read_addr: got %h want 00000010", o_raddr); else n_pass++;
    n_chk++; if (o_wr_cnt !== 1 || o_wr_cyc !== 4) $display("FAIL sb_write_cycle: got cnt %0d cyc %0d want 1 4", o_wr_cnt, o_wr_cyc); else n_pass++;
    n_chk++; if (o_wdata !== 32'hA522_3344) $display("FAIL sb_wdata: got %h want a5223344", o_wdata); else n_pass++;
    n_chk++; if (o_done_cyc !== 5 || o_idle_cyc !== 6) $display("FAIL sb_timing: got done %0d idle %0d want 5 6", o_done_cyc, o_idle_cyc); else n_pass++;
    ref_mem[4] = 32'hA522_3344;
    preload(6'd8, 32'h1122_3344);
    run_store(2'b01, 32'h0000_0022, 32'h0000_BEEF, 0);
    n_chk++; if (o_wdata !== 32'hBEEF_3344) $display("FAIL sh_upper_wdata: got %h want beef3344", o_wdata); else n_pass++;
    n_chk++; if (mem[8] !== 32'hBEEF_3344) $display("FAIL sh_upper_memory: got %h want beef3344", mem[8]); else n_pass++;
    preload(6'd8, 32'h1122_3344);
    run_store(2'b01, 32'h0000_0020, 32'h0000_BEEF, 0);
    n_chk++; if (o_wdata !== 32'h1122_BEEF) $display("FAIL sh_lower_wdata: got %h want 1122beef", o_wdata); else n_pass++;
    ref_mem[8] = 32'h1122_BEEF;
  endtask

  task automatic test_misaligned;
    preload(6'd8, 32'h1122_3344);
    run_store(2'b01, 32'h0000_0021, 32'h0000_BEEF, 0);
`ifdef STORE_ALIGN_CHECK_EN
    n_chk++; if (o_mis_cnt !== 1 || o_mis_cyc !== 1 || o_done_cyc !== 1) $display("FAIL sh_misaligned_pulse: got mis %0d@%0d done@%0d want 1@1 done@1", o_mis_cnt, o_mis_cyc, o_done_cyc); else n_pass++;
    n_chk++; if (o_wr_cnt !== 0) $display("FAIL sh_misaligned_no_write: got %0d writes want 0", o_wr_cnt); else n_pass++;
    n_chk++; if (mem[8] !== 32'h1122_3344) $display("FAIL sh_misaligned_memory: got %h want 11223344", mem[8]); else n_pass++;
`else
    n_chk++; if (o_mis_cnt !== 0) $display("FAIL sh_misaligned_flag: got %0d pulses want 0", o_mis_cnt); else n_pass++;
    n_chk++; if (o_wdata !== 32'h1122_BEEF || o_wr_cyc !== 4) $display("FAIL sh_misaligned_wdata: got %h@%0d want 1122beef@4", o_wdata, o_wr_cyc); else n_pass++;
    ref_mem[8] = 32'h1122_BEEF;
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] w; int wc, dc; bit f;
    preload(6'd4, 32'h5566_7788);
    start = 1'b1; size = 2'b10; addr = 32'h12; reg_data = 32'hAB;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_chk++; if ({busy, mem_wr, done} !== 3'b000) $display("FAIL mid_reset_async: got %b want 000", {busy, mem_wr, done}); else n_pass++;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    n_chk++; if (mem[4] !== 32'h5566_7788 || done !== 1'b0) $display("FAIL mid_reset_no_write: got %h done %b want 55667788 0", mem[4], done); else n_pass++;
    run_store(2'b00, 32'h0000_0014, 32'h0BAD_CAFE, 0);
    n_chk++; if (o_wr_cyc !== 1 || o_done_cyc !== 2 || o_idle_cyc !== 3) $display("FAIL post_reset_sw: got wr %0d done %0d idle %0d want 1 2 3", o_wr_cyc, o_done_cyc, o_idle_cyc); else n_pass++;
    ref_mem[5] = 32'h0BAD_CAFE;
    // Reset landing in WRITE must pull mem_wr low before the write edge.
    start = 1'b1; size = 2'b00; addr = 32'h18; reg_data = 32'h1234_5678;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    n_chk++; if (mem_wr !== 1'b1) $display("FAIL write_state_wr: got %b want 1", mem_wr); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_chk++; if (mem_wr !== 1'b0) $display("FAIL write_reset_async: got %b want 0", mem_wr); else n_pass++;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    n_chk++; if (mem[6] !== ref_mem[6] || done !== 1'b0) $display("FAIL write_reset_no_write: got %h done %b want %h 0", mem[6], done, ref_mem[6]); else n_pass++;
    model(2'b00, 32'h18, 32'h0, 32'h0, w, wc, dc, f);
  endtask

  task automatic test_start_ignored;
    logic [31:0] w, d; int wc, dc; bit f;
    preload(6'd9, $urandom);
    d = $urandom;
    model(2'b10, 32'h25, d, ref_mem[9], w, wc, dc, f);
    run_store(2'b10, 32'h0000_0025, d, 3);
    n_chk++; if (o_wr_cnt !== 1) $display("FAIL ignored_start_writes: got %0d want 1", o_wr_cnt); else n_pass++;
    n_chk++; if (o_wdata !== w || o_waddr !== 32'h24) $display("FAIL ignored_start_wdata: got %h@%h want %h@00000024", o_wdata, o_waddr, w); else n_pass++;
    n_chk++; if (o_done_cyc !== dc) $display("FAIL ignored_start_done: got %0d want %0d", o_done_cyc, dc); else n_pass++;
    ref_mem[9] = w;
  endtask

  task automatic test_back_to_back;
    logic [1:0] sz; logic [31:0] a, d, w; logic [5:0] idx; int wc, dc; bit f;
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom); a = $urandom; d = $urandom; idx = a[7:2];
      model(sz, a, d, ref_mem[idx], w, wc, dc, f);
      run_store(sz, a, d, 0);
      n_chk++; if (o_wr_cnt !== (f ? 0 : 1) || o_wr_cyc !== wc) $display("FAIL rand_write[%0d]: got cnt %0d cyc %0d want cyc %0d", i, o_wr_cnt, o_wr_cyc, wc); else n_pass++;
      n_chk++; if (o_done_cnt !== 1 || o_done_cyc !== dc || o_idle_cyc !== dc + 1) $display("FAIL rand_timing[%0d]: got done %0d idle %0d want %0d %0d", i, o_done_cyc, o_idle_cyc, dc, dc + 1); else n_pass++;
      n_chk++; if (o_mis_cnt !== int'(f)) $display("FAIL rand_misaligned[%0d]: got %0d want %0d", i, o_mis_cnt, int'(f)); else n_pass++;
      if (!f) begin
        n_chk++; if (o_wdata !== w || o_waddr !== {a[31:2], 2'b00}) $display("FAIL rand_wdata[%0d]: got %h@%h want %h@%h", i, o_wdata, o_waddr, w, {a[31:2], 2'b00}); else n_pass++;
        ref_mem[idx] = w;
      end
      n_chk++; if (mem[idx] !== ref_mem[idx]) $display("FAIL rand_memory[%0d]: got %h want %h", i, mem[idx], ref_mem[idx]); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; size = 2'b00; addr = '0; reg_data = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    test_reset;
    test_word;
    test_subword;
    test_misaligned;
    test_reset_mid;
    test_start_ignored;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
